// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential shift-add-3 (double-dabble) binary to packed BCD.
// Converts one WIDTH-bit unsigned value per WIDTH clocks.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   start - request conversion of bin (sampled only while idle)
//   bin   - unsigned binary input, latched on accepted start
//   busy  - high while a conversion is in progress
//   done  - one-cycle pulse, bcd holds a new result
//   bcd   - packed BCD, [3:0]=ones, [7:4]=tens, [11:8]=hundreds
module bin_to_bcd #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   dig_q, dig_d;
  logic [BW-1:0]   dig_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [BW+WIDTH-1:0] shl;

  // Add 3 to every digit >= 5 so the following shift carries into
  // the next decade correctly.
  always_comb begin
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shl = {dig_adj, shift_q} << 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          dig_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        dig_d   = shl[BW+WIDTH-1 -: BW];
        shift_d = shl[WIDTH-1:0];
        cnt_d   = cnt_q + CW'(1);
        // Last shift: publish the finished digits only now, so bcd
        // never shows a partial result.
        if (cnt_q == LAST) begin
          bcd_d   = shl[BW+WIDTH-1 -: BW];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == CONVERT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: directed bench with scoreboard for bin_to_bcd.
// Expected results are queued on accepted start and checked at done.
module tb_bin_to_bcd;

  localparam int W = 9;
  localparam int D = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy;
  logic          done;
  logic [4*D-1:0] bcd;

  always #5 clk = ~clk;

  bin_to_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [11:0] bcd_m = '0;
  logic [7:0]  opa, opb;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs,
                     input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock; model acceptance, done timing, busy and bcd hold.
  task automatic tick();
    logic         acc;
    logic         want;
    logic         bexp;
    logic [W-1:0] v;
    exp_t         e;
    acc = start && !busy && !reset;
    v   = bin;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      e.bcd = to_bcd(int'(v));
      e.due = cyc + W;
      sb.push_back(e);
    end
    want = (sb.size() > 0) && (sb[0].due == cyc);
    bexp = (sb.size() > 0) && (sb[0].due > cyc);
    chk("done", 12'(done), 12'(want));
    chk("busy", 12'(busy), 12'(bexp));
    if (want) begin
      bcd_m = sb[0].bcd;
      void'(sb.pop_front());
    end
    chk("bcd", bcd, bcd_m);
  endtask

  task automatic conv(input int v);
    bin   = W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 1) tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    #2;
    chk("rst_busy", 12'(busy), 12'd0);
    chk("rst_done", 12'(done), 12'd0);
    chk("rst_bcd", bcd, 12'h000);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    conv(0);
    conv(511);
    chk("bcd511", bcd, 12'h511);
    conv(255);
    conv(100);
    chk("bcd100", bcd, 12'h100);
    conv(9);
    opa = 8'd200;
    opb = 8'd55;
    conv(int'({1'b0, opa} + {1'b0, opb}));
    chk("adder255", bcd, 12'h255);

    // start while busy is ignored
    bin   = W'(300);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    bin   = W'(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = '0;
    repeat (W + 3) tick();
    chk("bcd300", bcd, 12'h300);

    // start held through the done cycle
    bin   = W'(123);
    start = 1'b1;
    tick();
    bin   = W'(456);
    repeat (10) tick();
    start = 1'b0;
    repeat (W + 2) tick();
    chk("bcd456", bcd, 12'h456);

    // reset mid-conversion
    conv(42);
    chk("bcd042", bcd, 12'h042);
    bin   = W'(499);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", 12'(busy), 12'd0);
    chk("arst_done", 12'(done), 12'd0);
    chk("arst_bcd", bcd, 12'h000);
    sb.delete();
    bcd_m = '0;
    tick();
    reset = 1'b0;
    tick();
    conv(499);
    chk("bcd499", bcd, 12'h499);

    // bin churns during conversion
    bin   = W'(88);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (W + 1) begin
      bin = W'($urandom_range(0, 511));
      tick();
    end
    chk("bcd088", bcd, 12'h088);
    chk("sb_empty", 12'(sb.size()), 12'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
